// File: rtl/uart_cmd_rx.sv
`timescale 1ns/1ps
// uart_cmd_rx
// Receive side of the cold-storage UART link. Deserializes 8N1 bytes from
// `rx` and parses short ASCII host commands ("M0\n", "F1\n", "T07\n", ...)
// that set the operating mode, manual actuator requests and the setpoints.
//
// Ports:
//   clk        in   system clock (1 MHz domain)
//   rst_n      in   asynchronous active-low reset
//   rx         in   UART line, idle high, asynchronous to clk
//   rx_data    out  last good received byte
//   rx_valid   out  1-cycle pulse, rx_data holds a new good byte
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   mode_auto  out  1 = auto, 0 = manual
//   fan_man    out  manual fan request
//   hum_man    out  manual humidifier request
//   temp_set   out  temperature setpoint, degC, 0-99
//   hum_set    out  humidity setpoint, %RH, 0-99
//   cmd_ok     out  1-cycle pulse, command applied
//   cmd_err    out  1-cycle pulse, command rejected
module uart_cmd_rx #(
    parameter int CLK_HZ = 1_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       mode_auto,
    output logic       fan_man,
    output logic       hum_man,
    output logic [7:0] temp_set,
    output logic [7:0] hum_set,
    output logic       cmd_ok,
    output logic       cmd_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_U  = 8'h55;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_ARG1, P_ARG2, P_END, P_DISCARD
    } p_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (preset high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             rx_tick, cnt_clr, bit_take, stop_good, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_sync) rx_next = RX_START;
            RX_START:     if (clk_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (clk_cnt == FULL_LAST && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:      if (clk_cnt == FULL_LAST) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    // Every sample point restarts the bit-period counter, so the start
    // sample lands mid-bit and each later sample one full period after it.
    always_comb begin
        rx_tick   = 1'b0;
        cnt_clr   = 1'b0;
        bit_take  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (rx_state)
            RX_START: rx_tick = (clk_cnt == HALF_LAST);
            RX_DATA: begin
                rx_tick  = (clk_cnt == FULL_LAST);
                bit_take = rx_tick;
            end
            RX_STOP: begin
                rx_tick   = (clk_cnt == FULL_LAST);
                stop_good = rx_tick && rx_sync;
                stop_bad  = rx_tick && !rx_sync;
            end
            default: cnt_clr = 1'b1;
        endcase
        if (rx_tick) cnt_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_cnt <= cnt_clr ? '0 : clk_cnt + CNT_W'(1);
            if (rx_state == RX_IDLE) bit_cnt <= '0;
            else if (bit_take)       bit_cnt <= bit_cnt + 3'd1;
            if (bit_take) shift_reg <= {rx_sync, shift_reg[7:1]};
            rx_valid  <= stop_good;
            frame_err <= stop_bad;
            if (stop_good) rx_data <= shift_reg;
        end
    end

    // ------------------------------------------------------------------
    // Command parser FSM
    // ------------------------------------------------------------------
    p_state_t   p_state, p_next;
    logic [7:0] op;
    logic [3:0] d1, d0;
    logic [7:0] arg_value;
    logic       is_cr, is_lf, is_digit, is_bin, is_op, op_single, arg1_ok;
    logic       ok_p, err_p, take_op, take_d1, take_d0;

    assign is_cr     = (rx_data == CH_CR);
    assign is_lf     = (rx_data == CH_LF);
    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_bin    = (rx_data == 8'h30) || (rx_data == 8'h31);
    assign is_op     = (rx_data == CH_M) || (rx_data == CH_F) || (rx_data == CH_H) ||
                       (rx_data == CH_T) || (rx_data == CH_U);
    assign op_single = (op == CH_M) || (op == CH_F) || (op == CH_H);
    assign arg1_ok   = op_single ? is_bin : is_digit;
    assign arg_value = {4'd0, d1} * 8'd10 + {4'd0, d0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_IDLE;
        else        p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (frame_err) begin
            p_next = P_IDLE;
        end else if (rx_valid && !is_cr) begin
            case (p_state)
                P_IDLE: begin
                    if (is_op)       p_next = P_ARG1;
                    else if (!is_lf) p_next = P_DISCARD;
                end
                P_ARG1: begin
                    if (arg1_ok)    p_next = op_single ? P_END : P_ARG2;
                    else if (is_lf) p_next = P_IDLE;
                    else            p_next = P_DISCARD;
                end
                P_ARG2: begin
                    if (is_digit)   p_next = P_END;
                    else if (is_lf) p_next = P_IDLE;
                    else            p_next = P_DISCARD;
                end
                P_END:     p_next = is_lf ? P_IDLE : P_DISCARD;
                P_DISCARD: if (is_lf) p_next = P_IDLE;
                default:   p_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        ok_p    = 1'b0;
        err_p   = 1'b0;
        take_op = 1'b0;
        take_d1 = 1'b0;
        take_d0 = 1'b0;
        if (!frame_err && rx_valid && !is_cr) begin
            case (p_state)
                P_IDLE: begin
                    if (is_op)       take_op = 1'b1;
                    else if (!is_lf) err_p   = 1'b1;
                end
                P_ARG1: begin
                    if (!arg1_ok)       err_p   = 1'b1;
                    else if (op_single) take_d0 = 1'b1;
                    else                take_d1 = 1'b1;
                end
                P_ARG2: begin
                    if (is_digit) take_d0 = 1'b1;
                    else          err_p   = 1'b1;
                end
                P_END: begin
                    // Manual actuator requests are refused while in auto mode.
                    if (!is_lf)                                       err_p = 1'b1;
                    else if ((op == CH_F || op == CH_H) && mode_auto) err_p = 1'b1;
                    else                                              ok_p  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= '0;
            d1        <= '0;
            d0        <= '0;
            cmd_ok    <= 1'b0;
            cmd_err   <= 1'b0;
            mode_auto <= 1'b1;
            fan_man   <= 1'b0;
            hum_man   <= 1'b0;
            temp_set  <= 8'd4;
            hum_set   <= 8'd90;
        end else begin
            cmd_ok  <= ok_p;
            cmd_err <= err_p;
            if (frame_err) begin
                op <= '0;
                d1 <= '0;
                d0 <= '0;
            end else begin
                if (take_op) op <= rx_data;
                if (take_d1) d1 <= rx_data[3:0];
                if (take_d0) d0 <= rx_data[3:0];
            end
            if (ok_p) begin
                case (op)
                    CH_M:    mode_auto <= d0[0];
                    CH_F:    fan_man   <= d0[0];
                    CH_H:    hum_man   <= d0[0];
                    CH_T:    temp_set  <= arg_value;
                    CH_U:    hum_set   <= arg_value;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
// Testbench for uart_cmd_rx: a table of command lines with expected settings,
// hand-written frame-error / break / reset / glitch sequences, and random
// bytes, all cross-checked per byte against a string-level command model.
module tb_uart_cmd_rx;

    localparam int CPB = 104;

    logic       clk, rst_n, rx;
    logic [7:0] rx_data, temp_set, hum_set;
    logic       rx_valid, frame_err, mode_auto, fan_man, hum_man, cmd_ok, cmd_err;

    uart_cmd_rx #(.CLK_HZ(1_000_000), .BAUD(9600)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .mode_auto(mode_auto), .fan_man(fan_man), .hum_man(hum_man),
        .temp_set(temp_set), .hum_set(hum_set),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    int n_checks = 0, n_errors = 0, byte_no = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (byte %0d): got 0x%0h, expected 0x%0h", name, byte_no, act, exp);
        end
    endfunction

    function automatic void chk_rng(string name, int val, int lo, int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_errors++;
            $display("FAIL %s (byte %0d): got %0d, expected %0d..%0d", name, byte_no, val, lo, hi);
        end
    endfunction

    // ---------------- pulse monitor ----------------
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_both = 0;
    int last_valid_cyc = 0, last_cmd_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin n_valid++; last_valid_cyc = cyc; end
        if (frame_err) n_ferr++;
        if (cmd_ok)  begin n_ok++;  last_cmd_cyc = cyc; end
        if (cmd_err) begin n_err++; last_cmd_cyc = cyc; end
        if (cmd_ok && cmd_err) n_both++;
    end

    function automatic int pulses();
        return n_valid + n_ferr + n_ok + n_err;
    endfunction

    // ---------------- reference model (line/prefix matching) ----------------
    logic [7:0] q[$];
    bit         m_disc;
    logic       m_mode, m_fan, m_hum;
    logic [7:0] m_temp, m_hset, m_rxd;

    function automatic void model_reset();
        m_mode = 1'b1; m_fan = 1'b0; m_hum = 1'b0;
        m_temp = 8'd4; m_hset = 8'd90; m_rxd = 8'h00;
        q.delete(); m_disc = 1'b0;
    endfunction

    function automatic int cmd_len(logic [7:0] c);
        if (c == "T" || c == "U") return 4;
        if (c == "M" || c == "F" || c == "H") return 3;
        return 0;
    endfunction

    // True while the bytes so far can still grow into a valid command line.
    function automatic bit prefix_ok();
        int len = cmd_len(q[0]);
        if (len == 0 || q.size() > len) return 1'b0;
        for (int i = 1; i < q.size(); i++) begin
            if (i == len - 1) begin
                if (q[i] != 8'h0A) return 1'b0;
            end else if (len == 3) begin
                if (q[i] != "0" && q[i] != "1") return 1'b0;
            end else if (q[i] < "0" || q[i] > "9") return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_byte(logic [7:0] b, output int ok, output int err);
        int v;
        ok = 0; err = 0;
        m_rxd = b;
        if (b == 8'h0D) return;
        if (m_disc) begin
            if (b == 8'h0A) m_disc = 1'b0;
            return;
        end
        q.push_back(b);
        if (q.size() == 1 && b == 8'h0A) begin q.delete(); return; end
        if (!prefix_ok()) begin
            err = 1;
            if (b != 8'h0A) m_disc = 1'b1;
            q.delete();
            return;
        end
        if (q.size() == cmd_len(q[0])) begin
            if ((q[0] == "F" || q[0] == "H") && m_mode) err = 1;
            else begin
                ok = 1;
                v = (int'(q[1]) - 48) * 10 + (int'(q[2]) - 48);
                case (q[0])
                    "M": m_mode = q[1][0];
                    "F": m_fan  = q[1][0];
                    "H": m_hum  = q[1][0];
                    "T": m_temp = v[7:0];
                    default: m_hset = v[7:0];
                endcase
            end
            q.delete();
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop_hi);
        int v0 = n_valid, f0 = n_ferr, o0 = n_ok, e0 = n_err;
        int mok = 0, merr = 0, t0;
        logic [9:0] frame = {stop_hi, b, 1'b0};
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_hi) model_byte(b, mok, merr);
        else begin q.delete(); m_disc = 1'b0; end
        byte_no++;
        chk("rx_valid pulses", 32'(n_valid - v0), 32'(stop_hi));
        chk("frame_err pulses", 32'(n_ferr - f0), 32'(!stop_hi));
        chk("cmd_ok pulses", 32'(n_ok - o0), 32'(mok));
        chk("cmd_err pulses", 32'(n_err - e0), 32'(merr));
        chk("outputs {rx_data,mode,fan,hum,temp,hum_set}",
            {5'd0, rx_data, mode_auto, fan_man, hum_man, temp_set, hum_set},
            {5'd0, m_rxd, m_mode, m_fan, m_hum, m_temp, m_hset});
        if (stop_hi) chk_rng("rx_valid latency from start edge", last_valid_cyc - t0, 980, 1000);
        if (mok + merr > 0) chk("cmd pulse delay after rx_valid", 32'(last_cmd_cyc - last_valid_cyc), 32'd1);
    endtask

    task automatic send_str(input logic [47:0] txt, input int n);
        for (int k = 0; k < n; k++) send_byte(txt[8*(n-1-k) +: 8], 1'b1);
    endtask

    typedef struct {
        logic [47:0] txt;
        int          n;
        int          ok;
        int          err;
        logic        mode, fan, hum;
        logic [7:0]  temp, hset;
    } vec_t;

    localparam logic [30:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd90, 1'b0, 1'b0};

    vec_t       vt [13];
    logic [7:0] pool [14];
    logic [7:0] mb;
    int         p, o0, e0;

    initial begin
        vt[0]  = '{48'("M0\n"),     3, 1, 0, 1'b0, 1'b0, 1'b0, 8'd4,  8'd90};
        vt[1]  = '{48'("F1\r\n"),   4, 1, 0, 1'b0, 1'b1, 1'b0, 8'd4,  8'd90};
        vt[2]  = '{48'("M1\n"),     3, 1, 0, 1'b1, 1'b1, 1'b0, 8'd4,  8'd90};
        vt[3]  = '{48'("H1\n"),     3, 0, 1, 1'b1, 1'b1, 1'b0, 8'd4,  8'd90};
        vt[4]  = '{48'("Q5\n"),     3, 0, 1, 1'b1, 1'b1, 1'b0, 8'd4,  8'd90};
        vt[5]  = '{48'("T07\n"),    4, 1, 0, 1'b1, 1'b1, 1'b0, 8'd7,  8'd90};
        vt[6]  = '{48'("U9\n"),     3, 0, 1, 1'b1, 1'b1, 1'b0, 8'd7,  8'd90};
        vt[7]  = '{48'("U65\n"),    4, 1, 0, 1'b1, 1'b1, 1'b0, 8'd7,  8'd65};
        vt[8]  = '{48'("m0\n"),     3, 0, 1, 1'b1, 1'b1, 1'b0, 8'd7,  8'd65};
        vt[9]  = '{48'("\n"),       1, 0, 0, 1'b1, 1'b1, 1'b0, 8'd7,  8'd65};
        vt[10] = '{48'("T99\n"),    4, 1, 0, 1'b1, 1'b1, 1'b0, 8'd99, 8'd65};
        vt[11] = '{48'("T123\n"),   5, 0, 1, 1'b1, 1'b1, 1'b0, 8'd99, 8'd65};
        vt[12] = '{48'("M2\n"),     3, 0, 1, 1'b1, 1'b1, 1'b0, 8'd99, 8'd65};
        pool = '{"M", "F", "H", "T", "U", "0", "1", "5", "9", 8'h0A, 8'h0D, "x", "m", "7"};

        // Reset and 2 ms of idle line
        rst_n = 1'b0; rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("reset values", {1'b0, rx_data, rx_valid, frame_err, mode_auto, fan_man, hum_man,
                             temp_set, hum_set, cmd_ok, cmd_err}, {1'b0, RESET_VEC});
        chk("no pulses while idle", 32'(pulses()), 32'd0);

        // Table of command lines
        for (int unsigned i = 0; i < 13; i++) begin
            o0 = n_ok; e0 = n_err;
            send_str(vt[i].txt, vt[i].n);
            chk("line cmd_ok count", 32'(n_ok - o0), 32'(vt[i].ok));
            chk("line cmd_err count", 32'(n_err - e0), 32'(vt[i].err));
            chk("line settings", {13'd0, mode_auto, fan_man, hum_man, temp_set, hum_set},
                {13'd0, vt[i].mode, vt[i].fan, vt[i].hum, vt[i].temp, vt[i].hset});
            chk("line rx_data", 32'(rx_data), 32'h0A);
        end

        // Frame error mid-command, then a 3-bit break
        send_byte("T", 1'b1);
        send_byte(8'h31, 1'b0);
        chk("rx_data kept on frame error", 32'(rx_data), 32'h54);
        p = pulses();
        repeat (3 * CPB) @(negedge clk);
        chk("break is quiet", 32'(pulses() - p), 32'd0);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        send_str(48'("T12\n"), 4);
        chk("temp_set after abort", 32'(temp_set), 32'd12);

        // Reset asserted during the data bits of 'M'
        send_str(48'("U50\n"), 4);
        chk("hum_set before reset", 32'(hum_set), 32'd50);
        mb = 8'h4D;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int unsigned i = 0; i < 3; i++) begin
            rx = mb[i];
            repeat (CPB) @(negedge clk);
        end
        rx = mb[3];
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-frame reset values", {1'b0, rx_data, rx_valid, frame_err, mode_auto, fan_man, hum_man,
                                       temp_set, hum_set, cmd_ok, cmd_err}, {1'b0, RESET_VEC});
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p = pulses();
        repeat (2 * CPB) @(negedge clk);
        chk("no partial byte after reset", 32'(pulses() - p), 32'd0);
        send_str(48'("M0\n"), 3);
        chk("mode_auto after reset+M0", 32'(mode_auto), 32'd0);

        // Start-bit glitch shorter than half a bit
        p = pulses();
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch ignored", 32'(pulses() - p), 32'd0);

        // Random bytes, occasional framing error
        for (int unsigned i = 0; i < 10; i++) begin
            bit stop_hi;
            stop_hi = ($urandom_range(0, 7) != 0);
            send_byte(pool[$urandom_range(0, 13)], stop_hi);
            if (!stop_hi) begin
                rx = 1'b1;
                repeat (20) @(negedge clk);
            end
        end

        chk("cmd_ok/cmd_err never together", 32'(n_both), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive side of the cold-storage UART link: deserializes 8N1 bytes arriving on `rx` and parses short ASCII commands from the host. The commands set the operating mode, manual fan/humidifier requests, and the temperature/humidity setpoints. It sits beside the DHT11-to-UART transmit path on the 1 MHz domain, and its registered outputs feed the LED/actuator control logic.

## Interface
- `CLK_HZ`, 1_000_000, clock frequency in Hz
- `BAUD`, 9600, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, 104 at defaults)
- `clk`  input  1  system clock (1 MHz domain)
- `rst_n`  input  1  reset, asynchronous, active-low
- `rx`  input  1  UART line, idle high, asynchronous to `clk`
- `rx_data`  output  8  last received byte (debug)
- `rx_valid`  output  1  one-cycle pulse: `rx_data` holds a good byte
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `mode_auto`  output  1  1 = auto, 0 = manual
- `fan_man`  output  1  manual fan request
- `hum_man`  output  1  manual humidifier request
- `temp_set`  output  8  temperature setpoint, °C, 0–99
- `hum_set`  output  8  humidity setpoint, %RH, 0–99
- `cmd_ok`  output  1  one-cycle pulse: command applied
- `cmd_err`  output  1  one-cycle pulse: command rejected

## Operation

**Reset values**
- `rx_data` = 0; `rx_valid`, `frame_err`, `cmd_ok`, `cmd_err` = 0.
- `mode_auto` = 1; `fan_man`, `hum_man` = 0.
- `temp_set` = 4; `hum_set` = 90.
- Receiver in RX_IDLE; parser in P_IDLE; synchronizer flops preset to 1.

**Receiver FSM**
- States: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH.
- `rx` passes through a 2-flop synchronizer before use.
- RX_IDLE: synchronized `rx`=0 → RX_START, bit counter cleared.
- RX_START: sample at `CLKS_PER_BIT/2`. Low → RX_DATA. High → glitch, return to RX_IDLE with no pulse.
- RX_DATA: 8 samples, one every `CLKS_PER_BIT`, LSB first.
- RX_STOP: sample one `CLKS_PER_BIT` after the last data bit.
  - High → `rx_data` updated, `rx_valid` pulses, → RX_IDLE.
  - Low → `frame_err` pulses, `rx_data` unchanged, → RX_WAIT_HIGH.
- RX_WAIT_HIGH: stay until synchronized `rx`=1, then → RX_IDLE. A break condition never retriggers reception.

**Parser FSM**
- States: P_IDLE, P_ARG1, P_ARG2, P_END, P_DISCARD.
- Acts only on cycles with `rx_valid`=1.
- 0x0D (`\r`) is ignored in every state.
- P_IDLE:
  - 'M', 'F', 'H' → P_ARG1, expecting one digit '0'/'1'.
  - 'T', 'U' → P_ARG1, expecting two decimal digits.
  - 0x0A → ignored (empty line).
  - Any other byte → `cmd_err`, → P_DISCARD.
- P_ARG1: digit valid for the opcode → held; go to P_END (M/F/H) or P_ARG2 (T/U).
- P_ARG2: decimal digit → held; → P_END.
- P_END: 0x0A → apply the command, `cmd_ok`, → P_IDLE.
- Any invalid byte in P_ARG1/P_ARG2/P_END → `cmd_err`.
  - Invalid byte is 0x0A → go straight to P_IDLE.
  - Otherwise → P_DISCARD.
- P_DISCARD: consume bytes until 0x0A, then → P_IDLE. No pulse on the terminator.
- A `frame_err` in any state aborts the parser to P_IDLE, discards held arguments, and raises no `cmd_err`.

**Command semantics**
- Value = 10·d1 + d0, computed in 8 bits, range 0–99.
- M sets `mode_auto`. Changing mode leaves `fan_man`/`hum_man` untouched.
- F / H are accepted only while `mode_auto`=0. If `mode_auto`=1, the 0x0A gives `cmd_err` instead of `cmd_ok`, and the output is unchanged.
- T sets `temp_set`; U sets `hum_set`.
- Only uppercase opcodes are accepted.

## Timing
- Synchronizer latency: 2 cycles.
- Start-bit sample: `CLKS_PER_BIT/2` cycles after the synchronized falling edge.
- Stop-bit sample: ≈9.5 bit periods after the start edge.
- `rx_valid`/`frame_err` assert the cycle after the stop sample, 1 cycle wide.
- Parser outputs are registered:
  - `cmd_ok`/`cmd_err` and the updated setting appear 1 cycle after the `rx_valid` that completes the command.
  - The setting changes in the same cycle that `cmd_ok` rises.
- `cmd_ok` and `cmd_err` are mutually exclusive.
- At most one command pulse per received byte.
- Asserting `rst_n` low mid-frame returns all state and outputs to reset values immediately. No partial byte survives.

## Test plan
- Release reset, line idle 2 ms → `mode_auto`=1, `fan_man`=0, `hum_man`=0, `temp_set`=4, `hum_set`=90, no pulses.
- Send "M0\n", then "F1\r\n" at 9600 baud → two `cmd_ok` pulses; `mode_auto`=0, `fan_man`=1; `rx_data`=0x0A after each frame.
- With `mode_auto`=1 send "H1\n" → one `cmd_err`, `hum_man` stays 0. Then "Q5\n" → `cmd_err` on 'Q', no pulse on '\n'.
- Send "T07\n" → `temp_set`=7. Then "U9\n" → `cmd_err` on '\n', `hum_set` stays 90. Then "U65\n" → `hum_set`=65.
- Send 'T', then a byte with stop bit forced low → `frame_err` pulse, parser aborted. Hold `rx` low 3 bit times → no extra pulses. Then "T12\n" → `temp_set`=12.
- Assert `rst_n` low during the data bits of 'M' after "U50\n" applied → all reset values, including `hum_set`=90. Then "M0\n" → `mode_auto`=0.
